// File: rtl/combo_pipe.sv
// Four-operand bitwise function unit with a LATENCY-deep valid/ready pipeline.
// Define COMBO_SWEEP_EN to add the on-chip truth-table sweep engine and its ports.
module combo_pipe #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o
`ifdef COMBO_SWEEP_EN
  ,
  input  logic             sweep_start,
  output logic             sweep_done,
  output logic [15:0]      truth,
  output logic             lane_mismatch
`endif
);

  function automatic logic [WIDTH-1:0] f_combo(input logic [1:0] m,
                                               input logic [WIDTH-1:0] fa,
                                               input logic [WIDTH-1:0] fb,
                                               input logic [WIDTH-1:0] fc,
                                               input logic [WIDTH-1:0] fd);
    case (m)
      2'd0:    f_combo = ~((fa & fb) | (fc ^ fd));
      2'd1:    f_combo = (fa & fb) | (fc ^ fd);
      2'd2:    f_combo = (fa | fb) & ~(fc ^ fd);
      default: f_combo = fa ^ fb ^ fc ^ fd;
    endcase
  endfunction

  logic [WIDTH-1:0] r_data [LATENCY];
  logic [LATENCY-1:0] r_v;

  logic             w_en;
  logic             w_load_v;
  logic [1:0]       w_mode;
  logic [WIDTH-1:0] w_a, w_b, w_c, w_d;
  logic [WIDTH-1:0] w_f;

`ifdef COMBO_SWEEP_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t       r_state, w_state_nxt;
  logic [3:0]   r_cnt;
  logic [1:0]   r_mode;
  logic [LATENCY-1:0] r_tag;
  logic [3:0]   r_idx [LATENCY];
  logic         w_issue;
  logic         w_sweep_last;
  logic         w_start_ok;

  // Sweep beats leaving the last stage are absorbed here, so they never stall.
  assign w_sweep_last = r_v[LATENCY-1] & r_tag[LATENCY-1];
  assign w_en         = ~r_v[LATENCY-1] | out_ready | w_sweep_last;
  assign w_issue      = (r_state == S_RUN);
  assign w_start_ok   = (r_state == S_IDLE) & sweep_start & (r_v == '0);
  assign in_ready     = w_en & ~rst & (r_state == S_IDLE);
  assign out_valid    = r_v[LATENCY-1] & ~r_tag[LATENCY-1];
  assign sweep_done   = (r_state == S_DONE);

  assign w_mode = w_issue ? r_mode : mode;
  assign w_a    = w_issue ? {WIDTH{r_cnt[3]}} : a;
  assign w_b    = w_issue ? {WIDTH{r_cnt[2]}} : b;
  assign w_c    = w_issue ? {WIDTH{r_cnt[1]}} : c;
  assign w_d    = w_issue ? {WIDTH{r_cnt[0]}} : d;
  assign w_load_v = (in_valid & in_ready) | w_issue;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
      S_RUN:   if (w_en && r_cnt == 4'hF) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_sweep_last && r_idx[LATENCY-1] == 4'hF) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_mode        <= 2'd0;
      truth         <= 16'd0;
      lane_mismatch <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_mode        <= mode;
        r_cnt         <= 4'd0;
        truth         <= 16'd0;
        lane_mismatch <= 1'b0;
      end
      if (w_issue && w_en) r_cnt <= r_cnt + 4'd1;
      if (w_sweep_last) begin
        truth[r_idx[LATENCY-1]] <= r_data[LATENCY-1][0];
        if (r_data[LATENCY-1] != {WIDTH{r_data[LATENCY-1][0]}}) lane_mismatch <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag <= '0;
      for (int k = 0; k < LATENCY; k++) r_idx[k] <= 4'd0;
    end else if (w_en) begin
      r_tag[0] <= w_issue;
      r_idx[0] <= r_cnt;
      for (int k = 1; k < LATENCY; k++) begin
        r_tag[k] <= r_tag[k-1];
        r_idx[k] <= r_idx[k-1];
      end
    end
  end
`else
  assign w_en      = ~r_v[LATENCY-1] | out_ready;
  assign in_ready  = w_en & ~rst;
  assign out_valid = r_v[LATENCY-1];
  assign w_mode    = mode;
  assign w_a       = a;
  assign w_b       = b;
  assign w_c       = c;
  assign w_d       = d;
  assign w_load_v  = in_valid & in_ready;
`endif

  assign w_f = f_combo(w_mode, w_a, w_b, w_c, w_d);
  assign o   = r_data[LATENCY-1];

  // Stage 0 captures the function result; later stages shift under the shared enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      for (int k = 0; k < LATENCY; k++) r_data[k] <= '0;
    end else if (w_en) begin
      r_v[0]    <= w_load_v;
      r_data[0] <= w_f;
      for (int k = 1; k < LATENCY; k++) begin
        r_v[k]    <= r_v[k-1];
        r_data[k] <= r_data[k-1];
      end
    end
  end

endmodule
